// File: rtl/reservation_station.sv
// Reservation station between issue/decode and the ALU: buffers instructions,
// snoops both CDBs for operands, dispatches the lowest-index ready entry per cycle.
module rs_entry #(
  parameter int ROB_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_in,
  input  logic             rdy_in,
  input  logic             alloc,
  input  logic             dispatch,
  input  logic [5:0]       issue_op,
  input  logic [6:0]       issue_opcode,
  input  logic [31:0]      issue_instruction,
  input  logic [31:0]      issue_pc,
  input  logic [31:0]      issue_imm,
  input  logic [ROB_W-1:0] issue_des,
  input  logic             issue_qj_busy,
  input  logic [ROB_W-1:0] issue_qj,
  input  logic [31:0]      issue_vj,
  input  logic             issue_qk_busy,
  input  logic [ROB_W-1:0] issue_qk,
  input  logic [31:0]      issue_vk,
  input  logic             alu_broadcast,
  input  logic [ROB_W-1:0] alu_entry,
  input  logic [31:0]      alu_result,
  input  logic             lsb_broadcast,
  input  logic [ROB_W-1:0] lsb_entry,
  input  logic [31:0]      lsb_result,
  output logic             busy,
  output logic             ready,
  output logic [5:0]       op,
  output logic [6:0]       opcode,
  output logic [31:0]      instruction,
  output logic [31:0]      pc,
  output logic [31:0]      imm,
  output logic [ROB_W-1:0] des,
  output logic [31:0]      vj,
  output logic [31:0]      vk
);
  logic             qj_busy, qk_busy;
  logic [ROB_W-1:0] qj, qk;
  logic             sj_busy, sk_busy, nj_busy, nk_busy;
  logic [ROB_W-1:0] sj_tag, sk_tag;
  logic [31:0]      nj_val, nk_val;
  logic             upd;

  assign ready = busy && !qj_busy && !qk_busy;
  assign upd   = !clear_in && rdy_in && (alloc || busy);

  // Operand source is the issue port on allocation, else the stored copy; ALU bus wins ties.
  always_comb begin
    sj_busy = alloc ? issue_qj_busy : qj_busy;
    sj_tag  = alloc ? issue_qj      : qj;
    nj_val  = alloc ? issue_vj      : vj;
    nj_busy = sj_busy;
    if (sj_busy && alu_broadcast && sj_tag == alu_entry) begin
      nj_busy = 1'b0;
      nj_val  = alu_result;
    end else if (sj_busy && lsb_broadcast && sj_tag == lsb_entry) begin
      nj_busy = 1'b0;
      nj_val  = lsb_result;
    end
    sk_busy = alloc ? issue_qk_busy : qk_busy;
    sk_tag  = alloc ? issue_qk      : qk;
    nk_val  = alloc ? issue_vk      : vk;
    nk_busy = sk_busy;
    if (sk_busy && alu_broadcast && sk_tag == alu_entry) begin
      nk_busy = 1'b0;
      nk_val  = alu_result;
    end else if (sk_busy && lsb_broadcast && sk_tag == lsb_entry) begin
      nk_busy = 1'b0;
      nk_val  = lsb_result;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy    <= 1'b0;
      qj_busy <= 1'b0;
      qk_busy <= 1'b0;
    end else if (clear_in) begin
      busy <= 1'b0;
    end else if (rdy_in) begin
      if (alloc)         busy <= 1'b1;
      else if (dispatch) busy <= 1'b0;
      if (alloc || busy) begin
        qj_busy <= nj_busy;
        qk_busy <= nk_busy;
      end
    end
  end

  // Payload is only observed while busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (upd) begin
      vj <= nj_val;
      vk <= nk_val;
    end
    if (!clear_in && rdy_in && alloc) begin
      op          <= issue_op;
      opcode      <= issue_opcode;
      instruction <= issue_instruction;
      pc          <= issue_pc;
      imm         <= issue_imm;
      des         <= issue_des;
      qj          <= issue_qj;
      qk          <= issue_qk;
    end
  end
endmodule

module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             issue_valid,
  input  logic [5:0]       issue_op,
  input  logic [6:0]       issue_opcode,
  input  logic [31:0]      issue_instruction,
  input  logic [31:0]      issue_pc,
  input  logic [31:0]      issue_imm,
  input  logic [ROB_W-1:0] issue_des,
  input  logic             issue_qj_busy,
  input  logic             issue_qk_busy,
  input  logic [ROB_W-1:0] issue_qj,
  input  logic [ROB_W-1:0] issue_qk,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic             alu_broadcast,
  input  logic [ROB_W-1:0] alu_entry,
  input  logic [31:0]      alu_result,
  input  logic             lsb_broadcast,
  input  logic [ROB_W-1:0] lsb_entry,
  input  logic [31:0]      lsb_result,
  output logic             rs_full,
  output logic             rs_new_calculate,
  output logic [6:0]       opcode,
  output logic [31:0]      rs_instruction,
  output logic [5:0]       rs_op,
  output logic [31:0]      rs_vj,
  output logic [31:0]      rs_vk,
  output logic [31:0]      rs_pc,
  output logic [31:0]      rs_imm,
  output logic [ROB_W-1:0] rs_des
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]            busy, ready, alloc, dispatch;
  logic [RS_SIZE-1:0][5:0]       e_op;
  logic [RS_SIZE-1:0][6:0]       e_opcode;
  logic [RS_SIZE-1:0][31:0]      e_inst, e_pc, e_imm, e_vj, e_vk;
  logic [RS_SIZE-1:0][ROB_W-1:0] e_des;
  logic [IDX_W-1:0]              free_idx, sel_idx;
  logic                          any_free, any_ready;

  assign rs_full = &busy;

  // Descending scan leaves the lowest matching index in the result.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    any_free  = 1'b0;
    any_ready = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
      if (ready[i]) begin
        sel_idx   = IDX_W'(i);
        any_ready = 1'b1;
      end
    end
  end

  always_comb begin
    alloc    = '0;
    dispatch = '0;
    if (issue_valid && any_free) alloc[free_idx] = 1'b1;
    if (any_ready)               dispatch[sel_idx] = 1'b1;
  end

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_entry
    rs_entry #(.ROB_W(ROB_W)) u_entry (
      .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in), .rdy_in(rdy_in),
      .alloc(alloc[g]), .dispatch(dispatch[g]),
      .issue_op(issue_op), .issue_opcode(issue_opcode),
      .issue_instruction(issue_instruction), .issue_pc(issue_pc),
      .issue_imm(issue_imm), .issue_des(issue_des),
      .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj), .issue_vj(issue_vj),
      .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk), .issue_vk(issue_vk),
      .alu_broadcast(alu_broadcast), .alu_entry(alu_entry), .alu_result(alu_result),
      .lsb_broadcast(lsb_broadcast), .lsb_entry(lsb_entry), .lsb_result(lsb_result),
      .busy(busy[g]), .ready(ready[g]),
      .op(e_op[g]), .opcode(e_opcode[g]), .instruction(e_inst[g]),
      .pc(e_pc[g]), .imm(e_imm[g]), .des(e_des[g]),
      .vj(e_vj[g]), .vk(e_vk[g])
    );
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rs_new_calculate <= 1'b0;
      opcode           <= '0;
      rs_instruction   <= '0;
      rs_op            <= '0;
      rs_vj            <= '0;
      rs_vk            <= '0;
      rs_pc            <= '0;
      rs_imm           <= '0;
      rs_des           <= '0;
    end else if (clear_in) begin
      rs_new_calculate <= 1'b0;
    end else if (rdy_in) begin
      rs_new_calculate <= any_ready;
      if (any_ready) begin
        opcode         <= e_opcode[sel_idx];
        rs_instruction <= e_inst[sel_idx];
        rs_op          <= e_op[sel_idx];
        rs_vj          <= e_vj[sel_idx];
        rs_vk          <= e_vk[sel_idx];
        rs_pc          <= e_pc[sel_idx];
        rs_imm         <= e_imm[sel_idx];
        rs_des         <= e_des[sel_idx];
      end
    end
  end
endmodule
